// File: rtl/pipe_chain.sv
// Elastic valid/ready register chain (DEPTH stages, bubble collapsing, per-stage flush).
// Define PIPE_CHAIN_SKID_EN for a one-entry input skid buffer with a registered in_ready.
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [DEPTH-1:0] flush,
  output logic [CNTW-1:0]  occupancy
);

  logic [DEPTH-1:0] validQ;
  logic [DEPTH-1:0] validD;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] killMask;
  logic [WIDTH-1:0] dataQ [DEPTH];
  logic             olderFull;
  logic             accept0;
  logic             anyFlush;
  logic             inXfer;
  logic             srcValid;
  logic             skidValidD;
  logic [WIDTH-1:0] srcData;
  logic [CNTW-1:0]  occQ;
  logic [CNTW-1:0]  occD;

  assign anyFlush = |flush;
  assign inXfer   = in_valid & in_ready;

  // A stage advances when any older stage is empty or the output is draining.
  // NOTE: every variable written here gets a value before any branch or loop, so no latch is inferred.
  always_comb begin
    adv       = '0;
    olderFull = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      olderFull = 1'b1;
      for (int j = i + 1; j < DEPTH; j++) olderFull = olderFull & validQ[j];
      adv[i] = out_ready | ~olderFull;
    end
  end

  // Stage i dies when any flush bit at index i or above is set (highest index wins).
  always_comb begin
    killMask = '0;
    for (int i = 0; i < DEPTH; i++) killMask[i] = |(flush >> i);
  end

  // Stage 0 takes a new item when it is empty or its own content moves on.
  assign accept0 = ~validQ[0] | adv[0];

`ifdef PIPE_CHAIN_SKID_EN
  logic             skidValidQ;
  logic             inReadyQ;
  logic [WIDTH-1:0] skidDataQ;

  assign in_ready   = inReadyQ & ~rst;
  assign srcValid   = skidValidQ | inXfer;
  assign srcData    = skidValidQ ? skidDataQ : in_data;
  assign skidValidD = srcValid & ~accept0 & ~anyFlush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skidValidQ <= 1'b0;
      skidDataQ  <= '0;
      inReadyQ   <= 1'b1;
    end else begin
      skidValidQ <= skidValidD;
      inReadyQ   <= ~skidValidD;
      if (~skidValidQ & inXfer & ~accept0) skidDataQ <= in_data;
    end
  end
`else
  assign in_ready   = accept0 & ~anyFlush & ~rst;
  assign srcValid   = inXfer;
  assign srcData    = in_data;
  assign skidValidD = 1'b0;
`endif

  // A transfer out of a killed stage never sets the receiving stage valid.
  always_comb begin
    validD    = '0;
    validD[0] = (srcValid & accept0) | (validQ[0] & ~adv[0]);
    for (int i = 1; i < DEPTH; i++) begin
      validD[i] = (validQ[i-1] & adv[i-1] & ~killMask[i-1]) | (validQ[i] & ~adv[i]);
    end
    validD = validD & ~killMask;
  end

  always_comb begin
    occD = CNTW'(skidValidD);
    for (int i = 0; i < DEPTH; i++) occD = occD + CNTW'(validD[i]);
  end

  // NOTE: stage payloads are reset because out_data must read zero out of reset; an empty stage otherwise just holds its data.
  // NOTE: sequential state uses <= so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ <= '0;
      occQ   <= '0;
      for (int i = 0; i < DEPTH; i++) dataQ[i] <= '0;
    end else begin
      validQ <= validD;
      occQ   <= occD;
      if (srcValid & accept0) dataQ[0] <= srcData;
      for (int i = 1; i < DEPTH; i++) begin
        if (validQ[i-1] & adv[i-1]) dataQ[i] <= dataQ[i-1];
      end
    end
  end

  assign out_valid = validQ[DEPTH-1] & ~rst;
  assign out_data  = dataQ[DEPTH-1];
  assign occupancy = occQ;

endmodule
